cursor_input_ctrl: RTL and testbench

CURSOR_INPUT_CTRL -- requirements
Module: cursor_input_ctrl

---
 rtl/cursor_input_ctrl_pkg.sv | 46 ++++
 rtl/cursor_input_ctrl_if.sv | 25 ++
 rtl/cursor_input_ctrl_btn_debounce.sv | 61 ++++++
 rtl/cursor_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_cursor_input_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/cursor_input_ctrl_pkg.sv
// Shared definitions for the cursor input controller, game logic and VGA renderer:
// grid geometry defaults, button indices, select FSM encoding and a wrap helper.
package cursor_input_ctrl_pkg;

    localparam int DEF_GRID_W   = 5;
    localparam int DEF_GRID_H   = 5;
    localparam int DEF_CELL_PX  = 32;
    localparam int DEF_ORIGIN_X = 5;
    localparam int DEF_ORIGIN_Y = 3;

    localparam int NUM_BTN   = 5;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLIP     = 2'd1,
        ST_WAIT_REL = 2'd2
    } flip_state_e;

    // Per-button view: synchronized raw level, debounced level, one-cycle press event.
    typedef struct packed {
        logic sync;
        logic level;
        logic press;
    } btn_evt_t;

    // One step along a wrapping axis; opposing requests cancel.
    function automatic logic [31:0] wrap_step(input logic [31:0] pos, input logic inc,
                                              input logic dec, input logic [31:0] size);
        logic [31:0] nxt;
        nxt = pos;
        if (inc && !dec) begin
            nxt = (pos == size - 32'd1) ? 32'd0 : pos + 32'd1;
        end else if (dec && !inc) begin
            nxt = (pos == 32'd0) ? size - 32'd1 : pos - 32'd1;
        end else begin
            nxt = pos;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cursor_input_ctrl_if.sv
// Button inputs, game status and cursor/flip outputs of the cursor input controller.
interface cursor_input_ctrl_if;

    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_sel;
    logic        game_over;
    logic        flip;
    logic [31:0] VGAid;
    logic [9:0]  x_topleft;
    logic [8:0]  y_topleft;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_sel, game_over,
        input  flip, VGAid, x_topleft, y_topleft
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_sel, game_over,
        output flip, VGAid, x_topleft, y_topleft
    );

endinterface

// File: rtl/cursor_input_ctrl_btn_debounce.sv
// Two-flop synchronizer, stable-level debouncer and rising-edge press event for one button.
module btn_debounce
    import cursor_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     btn_raw,
    output btn_evt_t evt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_d, sync1_q;
    logic             sync2_d, sync2_q;
    logic             level_d, level_q;
    logic             press_d, press_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Next-state: the counter only runs while the synchronized input disagrees with the debounced level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = CNT_ZERO;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = CNT_ZERO;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
        press_d = level_d & ~level_q;
    end

    // Debouncer state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign evt = '{sync: sync2_q, level: level_q, press: press_q};

endmodule

// File: rtl/cursor_input_ctrl.sv
// Cursor position on a wrapping grid driven by debounced buttons, plus the select
// FSM that issues a fixed-width flip pulse for the cell under the cursor.
module cursor_input_ctrl
    import cursor_input_ctrl_pkg::*;
#(
    parameter int GRID_W          = DEF_GRID_W,
    parameter int GRID_H          = DEF_GRID_H,
    parameter int CELL_PX         = DEF_CELL_PX,
    parameter int ORIGIN_X        = DEF_ORIGIN_X,
    parameter int ORIGIN_Y        = DEF_ORIGIN_Y,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FLIP_CYCLES     = 10
) (
    input  logic                clock,
    input  logic                reset,
    cursor_input_ctrl_if.slave  bus
);

    localparam int COL_W  = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int ROW_W  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int FCNT_W = (FLIP_CYCLES > 1) ? $clog2(FLIP_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLIP_CYCLES - 1);

    logic [NUM_BTN-1:0] raw_s;
    logic [NUM_BTN-1:0] press_s;
    btn_evt_t           btn_s [NUM_BTN];

    assign raw_s = {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (raw_s[i]),
            .evt     (btn_s[i])
        );
        assign press_s[i] = btn_s[i].press;
    end

    logic [COL_W-1:0]  col_d, col_q;
    logic [ROW_W-1:0]  row_d, row_q;
    logic [31:0]       vgaid_d, vgaid_q;
    logic [9:0]        x_d, x_q;
    logic [8:0]        y_d, y_q;

    flip_state_e       state_d, state_q;
    logic              flip_d, flip_q;
    logic [FCNT_W-1:0] fcnt_d, fcnt_q;
    logic [1:0]        settle_d, settle_q;
    logic              armed_d, armed_q;

    // Cursor next position and its derived index/pixel coordinates; frozen while flipping.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q != ST_FLIP) begin
            col_d = COL_W'(wrap_step(32'(col_q), press_s[BTN_RIGHT], press_s[BTN_LEFT], 32'(GRID_W)));
            row_d = ROW_W'(wrap_step(32'(row_q), press_s[BTN_DOWN], press_s[BTN_UP], 32'(GRID_H)));
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
        vgaid_d = 32'(row_d) * 32'(GRID_W) + 32'(col_d);
        x_d     = 10'(32'(ORIGIN_X) + 32'(col_d) * 32'(CELL_PX));
        y_d     = 9'(32'(ORIGIN_Y) + 32'(row_d) * 32'(CELL_PX));
    end

    // Cursor registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q   <= {COL_W{1'b0}};
            row_q   <= {ROW_W{1'b0}};
            vgaid_q <= 32'd0;
            x_q     <= 10'(ORIGIN_X);
            y_q     <= 9'(ORIGIN_Y);
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            vgaid_q <= vgaid_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Select FSM next state. A select still held from before a reset must be seen
    // released (once the synchronizer has refilled) before it is allowed to flip.
    always_comb begin
        state_d  = state_q;
        flip_d   = 1'b0;
        fcnt_d   = fcnt_q;
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd2) & ~btn_s[BTN_SEL].sync);
        case (state_q)
            ST_IDLE: begin
                if (press_s[BTN_SEL] && !bus.game_over && armed_q) begin
                    state_d = ST_FLIP;
                    flip_d  = 1'b1;
                    fcnt_d  = {FCNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLIP: begin
                if (fcnt_q == FCNT_LAST) begin
                    state_d = ST_WAIT_REL;
                    flip_d  = 1'b0;
                    fcnt_d  = {FCNT_W{1'b0}};
                end else begin
                    flip_d  = 1'b1;
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!btn_s[BTN_SEL].level) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                flip_d  = 1'b0;
                fcnt_d  = {FCNT_W{1'b0}};
            end
        endcase
    end

    // Select FSM registers, flip output registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            flip_q   <= 1'b0;
            fcnt_q   <= {FCNT_W{1'b0}};
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            flip_q   <= flip_d;
            fcnt_q   <= fcnt_d;
            settle_q <= settle_d;
            armed_q  <= armed_d;
        end
    end

    assign bus.flip      = flip_q;
    assign bus.VGAid     = vgaid_q;
    assign bus.x_topleft = x_q;
    assign bus.y_topleft = y_q;

endmodule

// File: tb/tb_cursor_input_ctrl.sv
// Directed and randomized checks of cursor_input_ctrl against a grid/flip reference model.
module tb_cursor_input_ctrl;

    localparam int GW = 5;
    localparam int GH = 5;
    localparam int CPX = 32;
    localparam int OX = 5;
    localparam int OY = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #10 clock = ~clock;

    cursor_input_ctrl_if bus ();

    cursor_input_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .CELL_PX(CPX), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .DEBOUNCE_CYCLES(4), .FLIP_CYCLES(10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          total = 0;
    int          bad = 0;
    int          flip_cycles = 0;
    int          flip_pulses = 0;
    int          flip_id_bad = 0;
    logic [31:0] flip_id_exp = 32'd0;
    logic        prev_flip = 1'b0;
    int          mcol = 0;
    int          mrow = 0;

    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.flip === 1'b1) begin
            flip_cycles++;
            if (!prev_flip) flip_pulses++;
            if (bus.VGAid !== flip_id_exp) flip_id_bad++;
        end
        prev_flip = (bus.flip === 1'b1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_flip();
        flip_cycles = 0;
        flip_pulses = 0;
        flip_id_bad = 0;
    endtask

    // mask bits: 0 up, 1 down, 2 left, 3 right
    task automatic press(input logic [3:0] mask, input int hold);
        bus.btn_up    = mask[0];
        bus.btn_down  = mask[1];
        bus.btn_left  = mask[2];
        bus.btn_right = mask[3];
        repeat (hold) tick();
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        repeat (12) tick();
    endtask

    task automatic press_sel(input int hold);
        bus.btn_sel = 1'b1;
        repeat (hold) tick();
        bus.btn_sel = 1'b0;
        repeat (12) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        mcol = 0;
        mrow = 0;
    endtask

    task automatic check_pos(input string tag, input int col, input int row);
        chk({tag, "_id"}, bus.VGAid, 32'(row * GW + col));
        chk({tag, "_x"}, 32'(bus.x_topleft), 32'((OX + col * CPX) % 1024));
        chk({tag, "_y"}, 32'(bus.y_topleft), 32'((OY + row * CPX) % 512));
    endtask

    initial begin
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0;
        bus.btn_right = 1'b0; bus.btn_sel = 1'b0; bus.game_over = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_flip", 32'(bus.flip), 32'd0);
        check_pos("reset", 0, 0);
        reset = 1'b0;
        tick();

        // bounce: high runs of 1,2,1,2 cycles never reach the debounce length
        bus.btn_right = 1'b1; tick(); bus.btn_right = 1'b0; tick();
        bus.btn_right = 1'b1; repeat (2) tick(); bus.btn_right = 1'b0; tick();
        bus.btn_right = 1'b1; tick(); bus.btn_right = 1'b0; tick();
        bus.btn_right = 1'b1; repeat (2) tick(); bus.btn_right = 1'b0;
        repeat (12) tick();
        chk("bounce_id", bus.VGAid, 32'd0);

        // held right: exactly one step
        bus.btn_right = 1'b1;
        repeat (20) tick();
        check_pos("hold_right", 1, 0);
        bus.btn_right = 1'b0;
        repeat (12) tick();
        chk("hold_right_once", bus.VGAid, 32'd1);

        // wrap left then up
        do_reset();
        press(4'b0100, 12);
        check_pos("wrap_left", 4, 0);
        press(4'b0001, 12);
        check_pos("wrap_up", 4, 4);

        // flip pulse at cell 9 with a move attempted during the pulse
        do_reset();
        press(4'b0100, 12);
        press(4'b0010, 12);
        chk("at9", bus.VGAid, 32'd9);
        clr_flip();
        flip_id_exp = 32'd9;
        bus.btn_sel = 1'b1;
        repeat (3) tick();
        bus.btn_right = 1'b1;
        repeat (30) tick();
        chk("flip1_len", 32'(flip_cycles), 32'd10);
        chk("flip1_pulses", 32'(flip_pulses), 32'd1);
        chk("flip1_id_stable", 32'(flip_id_bad), 32'd0);
        bus.btn_sel = 1'b0;
        bus.btn_right = 1'b0;
        repeat (12) tick();
        chk("flip1_after_id", bus.VGAid, 32'd9);
        chk("flip1_after_flip", 32'(bus.flip), 32'd0);
        clr_flip();
        press_sel(30);
        chk("flip2_len", 32'(flip_cycles), 32'd10);
        chk("flip2_pulses", 32'(flip_pulses), 32'd1);

        // game over: select ignored, moves still work
        press(4'b1000, 12);
        press(4'b0010, 12);
        press(4'b0010, 12);
        chk("at15", bus.VGAid, 32'd15);
        bus.game_over = 1'b1;
        clr_flip();
        press_sel(30);
        chk("gameover_noflip", 32'(flip_cycles), 32'd0);
        press(4'b1000, 12);
        check_pos("gameover_move", 1, 3);
        bus.game_over = 1'b0;

        // reset in the middle of a pulse with select held
        clr_flip();
        flip_id_exp = 32'd16;
        bus.btn_sel = 1'b1;
        for (int i = 0; i < 40 && flip_cycles < 5; i++) tick();
        chk("midflip_reached", 32'(flip_cycles), 32'd5);
        reset = 1'b1;
        tick();
        chk("midflip_rst_flip", 32'(bus.flip), 32'd0);
        chk("midflip_rst_id", bus.VGAid, 32'd0);
        reset = 1'b0;
        flip_id_exp = 32'd0;
        clr_flip();
        repeat (40) tick();
        chk("held_after_rst_noflip", 32'(flip_cycles), 32'd0);
        bus.btn_sel = 1'b0;
        repeat (12) tick();
        clr_flip();
        press_sel(30);
        chk("repress_len", 32'(flip_cycles), 32'd10);
        chk("repress_pulses", 32'(flip_pulses), 32'd1);

        // randomized simultaneous moves against the grid model
        do_reset();
        for (int n = 0; n < 25; n++) begin
            logic [3:0] m;
            m = 4'($urandom_range(1, 15));
            bus.game_over = 1'($urandom_range(0, 1));
            press(m, 12);
            mcol = (mcol + int'(m[3]) - int'(m[2]) + GW) % GW;
            mrow = (mrow + int'(m[1]) - int'(m[0]) + GH) % GH;
            check_pos("rand", mcol, mrow);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
